// File: rtl/i2c_responder_if.sv
// I2C responder bus bundle.
//   i_scl, i_sda : I2C lines as seen by the responder (asynchronous to the system clock)
//   o_sda_oe     : 1 = responder pulls SDA low
//   o_reg_data   : last complete two-byte write payload
//   o_valid      : one-cycle pulse when o_reg_data is updated
//   o_error      : one-cycle pulse when an addressed write ends with a byte count other than 2
//   o_busy       : addressed transaction in progress
// slave modport is taken by the responder, master by the bus driver.
`timescale 1ns/1ps
interface i2c_responder_if;
  logic        i_scl;
  logic        i_sda;
  logic        o_sda_oe;
  logic [15:0] o_reg_data;
  logic        o_valid;
  logic        o_error;
  logic        o_busy;

  modport slave  (input  i_scl, i_sda,
                  output o_sda_oe, o_reg_data, o_valid, o_error, o_busy);
  modport master (output i_scl, i_sda,
                  input  o_sda_oe, o_reg_data, o_valid, o_error, o_busy);
endinterface

// File: rtl/i2c_responder.sv
// I2C write-only target: accepts START, address (write), exactly two data
// bytes and STOP, then publishes the 16-bit payload with a one-cycle o_valid.
// Wrong byte counts on an addressed write give a one-cycle o_error.
// Ports:
//   i_clk : system clock (>= 8x SCL)
//   i_rst : synchronous active-high reset
//   bus   : i2c_responder_if.slave (SCL/SDA in, SDA pull-down and status out)
// Parameters: ADDR (7-bit target address), SYNC_STAGES (synchronizer depth).
// Optional macro I2C_RESPONDER_FILTER_EN: a synced SCL/SDA level change is
// accepted only after 3 equal consecutive samples (2 extra cycles latency).
`timescale 1ns/1ps
module i2c_responder #(
  parameter logic [6:0] ADDR        = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  i2c_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_BYTE, S_ACK_BYTE, S_IGNORE
  } state_t;

  // ---------------- input conditioning ----------------
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_s, sda_s, scl_lvl, sda_lvl;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q[0] <= bus.i_scl;
      sda_sync_q[0] <= bus.i_sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_RESPONDER_FILTER_EN
  // Two-deep history; the accepted level (held in *_prev_q) only moves when
  // the current synced sample and both history samples agree.
  logic [1:0] scl_h_q, sda_h_q;
  assign scl_lvl = (scl_s == scl_h_q[0] && scl_s == scl_h_q[1]) ? scl_s : scl_prev_q;
  assign sda_lvl = (sda_s == sda_h_q[0] && sda_s == sda_h_q[1]) ? sda_s : sda_prev_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_h_q <= '1;
      sda_h_q <= '1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_s};
      sda_h_q <= {sda_h_q[0], sda_s};
    end
  end
`else
  assign scl_lvl = scl_s;
  assign sda_lvl = sda_s;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_lvl;
      sda_prev_q <= sda_lvl;
    end
  end

  logic scl_rise, scl_fall, scl_high, start_c, stop_c;
  assign scl_rise = scl_lvl & ~scl_prev_q;
  assign scl_fall = ~scl_lvl & scl_prev_q;
  assign scl_high = scl_lvl & scl_prev_q;
  assign start_c  = scl_high & ~sda_lvl &  sda_prev_q;
  assign stop_c   = scl_high &  sda_lvl & ~sda_prev_q;

  // ---------------- protocol FSM ----------------
  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;     // completed bits of current byte
  logic [1:0]  byte_cnt_q, byte_cnt_d;   // data bytes accepted
  logic        pend_q, pend_d;           // a bit was sampled, its SCL fall not seen yet
  logic [7:0]  shift_q, shift_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] reg_q, reg_d;
  logic        ovf_q, ovf_d;
  logic        match_q, match_d;
  logic        oe_q, oe_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      pend_q     <= 1'b0;
      shift_q    <= '0;
      shadow_q   <= '0;
      reg_q      <= '0;
      ovf_q      <= 1'b0;
      match_q    <= 1'b0;
      oe_q       <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pend_q     <= pend_d;
      shift_q    <= shift_d;
      shadow_q   <= shadow_d;
      reg_q      <= reg_d;
      ovf_q      <= ovf_d;
      match_q    <= match_d;
      oe_q       <= oe_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    pend_d     = pend_q;
    shift_d    = shift_q;
    shadow_d   = shadow_q;
    reg_d      = reg_q;
    ovf_d      = ovf_q;
    match_d    = match_q;
    oe_d       = oe_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;

    if (start_c) begin
      // also covers repeated START: partial byte and counts are dropped
      state_d    = S_ADDR;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      pend_d     = 1'b0;
      ovf_d      = 1'b0;
      match_d    = 1'b0;
      oe_d       = 1'b0;
    end else if (stop_c) begin
      // the STOP's own SCL rise only sets pend, so a clean end has bit_cnt == 0
      if (match_q) begin
        if (byte_cnt_q == 2'd2 && !ovf_q && bit_cnt_q == 3'd0) begin
          valid_d = 1'b1;
          reg_d   = shadow_q;
        end else begin
          error_d = 1'b1;
        end
      end
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      pend_d    = 1'b0;
      ovf_d     = 1'b0;
      match_d   = 1'b0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_BYTE: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_lvl};
            pend_d  = 1'b1;
          end else if (scl_fall && pend_q) begin
            pend_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              if (state_q == S_ADDR) begin
                if (shift_q[7:1] == ADDR && !shift_q[0]) begin
                  state_d = S_ACK_ADDR;
                  oe_d    = 1'b1;
                  match_d = 1'b1;
                end else begin
                  state_d = S_IGNORE;
                end
              end else if (byte_cnt_q != 2'd2) begin
                if (byte_cnt_q == 2'd0) shadow_d[15:8] = shift_q;
                else                    shadow_d[7:0]  = shift_q;
                byte_cnt_d = byte_cnt_q + 2'd1;
                state_d    = S_ACK_BYTE;
                oe_d       = 1'b1;
              end else begin
                ovf_d   = 1'b1;
                state_d = S_IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        S_ACK_ADDR, S_ACK_BYTE: begin
          // 9th SCL rise is ignored; its fall ends the ACK slot
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = S_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_sda_oe   = oe_q;
  assign bus.o_reg_data = reg_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_error    = error_q;
  assign bus.o_busy     = (state_q == S_ACK_ADDR) || (state_q == S_BYTE) ||
                          (state_q == S_ACK_BYTE) || (state_q == S_IGNORE && ovf_q);

endmodule

// File: tb/tb_i2c_responder.sv
// Directed bench for i2c_responder: drives an open-drain I2C bus model and
// checks ACK/NACK, payload capture, pulses, busy and reset behaviour.
`timescale 1ns/1ps
module tb_i2c_responder;
  localparam int H = 16;  // SCL half period in system clocks

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  int errors = 0;
  int checks = 0;
  int valid_cnt = 0, err_cnt = 0, oe_cnt = 0;

  always #5 clk = ~clk;

  i2c_responder_if bus();
  assign bus.i_scl = scl_drv;
  assign bus.i_sda = sda_drv & ~bus.o_sda_oe;  // wired-AND with the responder pull-down

  i2c_responder #(.ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.o_valid)  valid_cnt <= valid_cnt + 1;
    if (bus.o_error)  err_cnt   <= err_cnt + 1;
    if (bus.o_sda_oe) oe_cnt    <= oe_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    wait_clks(H/2);
    sda_drv = b;
    if (glitch) begin
      wait_clks(H/4);
      scl_drv = 1'b1;
      wait_clks(1);
      scl_drv = 1'b0;
      wait_clks(H/4 - 1);
    end else begin
      wait_clks(H/2);
    end
    scl_drv = 1'b1;
    wait_clks(H);
    scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
    wait_clks(H/2);
    sda_drv = 1'b1;
    wait_clks(H/2);
    scl_drv = 1'b1;
    wait_clks(H/2);
    ack = bus.o_sda_oe;
    wait_clks(H/2);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl_drv == 1'b0) begin
      wait_clks(H/2);
      sda_drv = 1'b1;
      wait_clks(H/2);
      scl_drv = 1'b1;
      wait_clks(H/2);
    end
    sda_drv = 1'b0;
    wait_clks(H/2);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(H/2);
    sda_drv = 1'b0;
    wait_clks(H/2);
    scl_drv = 1'b1;
    wait_clks(H);
    sda_drv = 1'b1;
    wait_clks(H);
  endtask

  task automatic test_reset();
    wait_clks(4);
    checks++; if (bus.o_sda_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", bus.o_sda_oe); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", bus.o_error); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_reg_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.o_reg_data); end
    rst = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_write();
    int v0, e0;
    logic a1, a2, a3;
    v0 = valid_cnt; e0 = err_cnt;
    i2c_start();
    send_byte(8'h34, -1, a1);
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", bus.o_busy); end
    send_byte(8'h1E, -1, a2);
    send_byte(8'h00, -1, a3);
    checks++; if ({a1, a2, a3} !== 3'b111) begin errors++; $display("FAIL write_acks: got %b want 111", {a1, a2, a3}); end
    wait_clks(H/2 - 1);
    checks++; if (bus.o_sda_oe !== 1'b0) begin errors++; $display("FAIL write_release: got %b want 0", bus.o_sda_oe); end
    i2c_stop();
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL write_valid: got %0d pulses want 1", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL write_error: got %0d pulses want 0", err_cnt - e0); end
    checks++; if (bus.o_reg_data !== 16'h1E00) begin errors++; $display("FAIL write_data: got %h want 1e00", bus.o_reg_data); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL write_idle_busy: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_addr_mismatch();
    int v0, e0, o0;
    logic a;
    v0 = valid_cnt; e0 = err_cnt; o0 = oe_cnt;
    i2c_start();
    send_byte(8'h36, -1, a);
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b want 0", bus.o_busy); end
    send_byte(8'h55, -1, a);
    i2c_stop();
    checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL mismatch_oe: got %0d oe cycles want 0", oe_cnt - o0); end
    checks++; if ((valid_cnt - v0) + (err_cnt - e0) !== 0) begin errors++; $display("FAIL mismatch_pulse: got %0d pulses want 0", (valid_cnt - v0) + (err_cnt - e0)); end
    checks++; if (bus.o_reg_data !== 16'h1E00) begin errors++; $display("FAIL mismatch_data: got %h want 1e00", bus.o_reg_data); end
  endtask

  task automatic test_read();
    int v0, e0;
    logic a;
    v0 = valid_cnt; e0 = err_cnt;
    i2c_start();
    send_byte(8'h35, -1, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL read_nack: got %b want 0", a); end
    i2c_stop();
    checks++; if ((valid_cnt - v0) + (err_cnt - e0) !== 0) begin errors++; $display("FAIL read_pulse: got %0d pulses want 0", (valid_cnt - v0) + (err_cnt - e0)); end
  endtask

  task automatic test_overflow();
    int v0, e0;
    logic a1, a2, a3, a4;
    v0 = valid_cnt; e0 = err_cnt;
    i2c_start();
    send_byte(8'h34, -1, a1);
    send_byte(8'h12, -1, a2);
    send_byte(8'h34, -1, a3);
    send_byte(8'h56, -1, a4);
    checks++; if ({a1, a2, a3, a4} !== 4'b1110) begin errors++; $display("FAIL ovf_acks: got %b want 1110", {a1, a2, a3, a4}); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b want 1", bus.o_busy); end
    i2c_stop();
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL ovf_error: got %0d pulses want 1", err_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ovf_valid: got %0d pulses want 0", valid_cnt - v0); end
    checks++; if (bus.o_reg_data !== 16'h1E00) begin errors++; $display("FAIL ovf_data: got %h want 1e00", bus.o_reg_data); end
  endtask

  task automatic test_short();
    int v0, e0;
    logic a1, a2;
    v0 = valid_cnt; e0 = err_cnt;
    i2c_start();
    send_byte(8'h34, -1, a1);
    send_byte(8'h77, -1, a2);
    i2c_stop();
    checks++; if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin errors++; $display("FAIL short_pulses: got err=%0d val=%0d want err=1 val=0", err_cnt - e0, valid_cnt - v0); end
    checks++; if (bus.o_reg_data !== 16'h1E00) begin errors++; $display("FAIL short_data: got %h want 1e00", bus.o_reg_data); end
  endtask

  task automatic test_repeated_start();
    int v0, e0;
    logic a1, a2, a3, a4;
    v0 = valid_cnt; e0 = err_cnt;
    i2c_start();
    send_byte(8'h34, -1, a1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    i2c_start();
    send_byte(8'h34, -1, a2);
    send_byte(8'hAB, -1, a3);
    send_byte(8'hCD, -1, a4);
    checks++; if ({a1, a2, a3, a4} !== 4'b1111) begin errors++; $display("FAIL rstart_acks: got %b want 1111", {a1, a2, a3, a4}); end
    i2c_stop();
    checks++; if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin errors++; $display("FAIL rstart_pulses: got val=%0d err=%0d want val=1 err=0", valid_cnt - v0, err_cnt - e0); end
    checks++; if (bus.o_reg_data !== 16'hABCD) begin errors++; $display("FAIL rstart_data: got %h want abcd", bus.o_reg_data); end
  endtask

  task automatic test_reset_during_ack();
    int v0;
    logic a1, a2, a3;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h34 >> i), 1'b0);
    wait_clks(H/2);
    checks++; if (bus.o_sda_oe !== 1'b1) begin errors++; $display("FAIL rst_ack_oe_before: got %b want 1", bus.o_sda_oe); end
    rst = 1'b1;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    wait_clks(1);
    checks++; if (bus.o_sda_oe !== 1'b0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_ack_release: got oe=%b busy=%b want 0 0", bus.o_sda_oe, bus.o_busy); end
    wait_clks(3);
    rst = 1'b0;
    wait_clks(4);
    checks++; if (bus.o_reg_data !== 16'h0000) begin errors++; $display("FAIL rst_ack_data: got %h want 0000", bus.o_reg_data); end
    v0 = valid_cnt;
    i2c_start();
    send_byte(8'h34, -1, a1);
    send_byte(8'hBE, -1, a2);
    send_byte(8'hEF, -1, a3);
    i2c_stop();
    checks++; if (valid_cnt - v0 !== 1 || bus.o_reg_data !== 16'hBEEF) begin errors++; $display("FAIL rst_recover: got val=%0d data=%h want 1 beef", valid_cnt - v0, bus.o_reg_data); end
  endtask

  task automatic test_glitch();
    int v0, e0;
    logic a1, a2, a3;
    v0 = valid_cnt; e0 = err_cnt;
    i2c_start();
    send_byte(8'h34, -1, a1);
    send_byte(8'h1E, 3, a2);
    send_byte(8'h00, -1, a3);
    i2c_stop();
`ifdef I2C_RESPONDER_FILTER_EN
    checks++; if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_pulses: got val=%0d err=%0d want 1 0", valid_cnt - v0, err_cnt - e0); end
    checks++; if (bus.o_reg_data !== 16'h1E00) begin errors++; $display("FAIL glitch_data: got %h want 1e00", bus.o_reg_data); end
`else
    checks++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 1) begin errors++; $display("FAIL glitch_pulses: got val=%0d err=%0d want 0 1", valid_cnt - v0, err_cnt - e0); end
    checks++; if (bus.o_reg_data !== 16'hBEEF) begin errors++; $display("FAIL glitch_data: got %h want beef", bus.o_reg_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_overflow();
    test_short();
    test_repeated_start();
    test_reset_during_ack();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_responder.md
I2C_RESPONDER -- requirements
Module: i2c_responder

Interface
REQ-001 SHALL have parameter ADDR, default 7'h1A, 7-bit target address to which the block responds.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops on i_scl and i_sda.
REQ-003 i_clk  input  1  system clock; free-running, at least 8x the SCL frequency.
REQ-004 i_rst  input  1  reset; synchronous, active-high, single clock domain i_clk.
REQ-005 i_scl  input  1  I2C clock line, asynchronous to i_clk.
REQ-006 i_sda  input  1  I2C data line, asynchronous to i_clk.
REQ-007 o_sda_oe  output  1  1 = pull SDA low (ACK); 0 = release the line.
REQ-008 o_reg_data  output  16  last complete write payload, first received byte in [15:8].
REQ-009 o_valid  output  1  one-cycle pulse; o_reg_data updated in the same cycle.
REQ-010 o_error  output  1  one-cycle pulse; an addressed write ended with a byte count other than 2.
REQ-011 o_busy  output  1  1 while between START and STOP with address matched.

Function
REQ-012 SHALL synchronize i_scl/i_sda through SYNC_STAGES flops, then register once more for edge detection; a pin edge is therefore acted on SYNC_STAGES+1 cycles after it occurs.
REQ-013 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-014 States: S_IDLE, S_ADDR, S_ACK_ADDR, S_BYTE, S_ACK_BYTE, S_IGNORE.
REQ-015 START from any state -> S_ADDR, bit counter = 0, byte counter = 0, any partial byte discarded (covers repeated START).
REQ-016 S_ADDR/S_BYTE shift in SDA MSB-first on each SCL rising edge; after the 8th bit, the next SCL falling edge ends the byte.
REQ-017 Address byte: upper 7 bits == ADDR and R/W = 0 -> S_ACK_ADDR; otherwise -> S_IGNORE with o_sda_oe held at 0 (NACK).
REQ-018 S_ACK_ADDR/S_ACK_BYTE: o_sda_oe = 1 from the 8th SCL falling edge to the 9th SCL falling edge, then 0; next state is S_BYTE.
REQ-019 Data bytes 1 and 2 are stored into [15:8] and [7:0] of a shadow register, and each is ACKed.
REQ-020 A 3rd data byte is NACKed -> S_IGNORE, with an overflow flag set.
REQ-021 STOP with byte count == 2, no overflow and bit counter == 0 -> o_reg_data <= shadow and o_valid = 1 for one cycle -> S_IDLE.
REQ-022 STOP after a matched address in any other condition (0/1 bytes, partial byte, overflow) -> o_error = 1 for one cycle, o_reg_data unchanged -> S_IDLE.
REQ-023 STOP with no matched address (mismatch or read) -> S_IDLE with no pulse.
REQ-024 S_IGNORE: o_sda_oe = 0; leaves only on START or STOP.
REQ-025 STOP while o_sda_oe = 1 (protocol violation) -> o_sda_oe = 0 in the same cycle the state returns to S_IDLE.
REQ-026 o_busy = 1 in S_ACK_ADDR, S_BYTE and S_ACK_BYTE, and in S_IGNORE only when entered by overflow.

Reset
REQ-027 When i_rst = 1 at a rising edge of i_clk: state = S_IDLE, counters = 0, o_sda_oe = 0, o_valid = 0, o_error = 0, o_busy = 0, o_reg_data = 16'h0000, synchronizer and filter flops = 1.
REQ-028 Reset during a transaction SHALL release SDA on the cycle after the reset edge; the block then waits for a new START.

Configuration
REQ-029 Macro I2C_RESPONDER_FILTER_EN defined: a synced SCL/SDA level change is accepted only after 3 consecutive equal samples, adding 2 cycles of latency.
REQ-030 I2C_RESPONDER_FILTER_EN undefined: synchronizer only; every synced transition is accepted immediately.

Verification
REQ-031 START, 0x34, 0x1E, 0x00, STOP -> o_sda_oe = 1 during the three 9th clocks; o_valid pulse with o_reg_data = 16'h1E00, no o_error.
REQ-032 START, 0x36 (address 0x1B) -> o_sda_oe stays 0 throughout; no o_valid or o_error at STOP.
REQ-033 START, 0x35 (read) -> NACK; no pulse at STOP.
REQ-034 START, 0x34, 0x12, 0x34, 0x56, STOP -> first three bytes ACKed, 0x56 NACKed, o_error pulse, o_reg_data unchanged.
REQ-035 Repeated START after 4 bits of a data byte, then 0x34, 0xAB, 0xCD, STOP -> o_reg_data = 16'hABCD, o_valid pulse; i_rst asserted during an ACK -> o_sda_oe = 0 next cycle.
REQ-036 With I2C_RESPONDER_FILTER_EN, a 1-cycle SCL glitch mid-bit is ignored and 16'h1E00 is received correctly; without it, the same stimulus produces an o_error pulse.
